// File: rtl/riscv_mem_pkg.sv
// ---------------------------------------------------------------------------
// riscv_mem_pkg
// Shared definitions for the instruction-memory slice of the RISC-V core.
//   RV_NOP_WORD  : canonical NOP (addi x0,x0,0). The pipeline flush logic
//                  injects the same word.
//   imem_state_e : boot-load / run state of the loadable instruction memory.
//   fetch_src_e  : selects what drives fetch_data after a fetch.
//   word_idx_w() : width of the word index carved out of a byte address.
// ---------------------------------------------------------------------------
package riscv_mem_pkg;

    localparam logic [31:0] RV_NOP_WORD = 32'h0000_0013;

    typedef enum logic {
        IMEM_LOAD = 1'b0,
        IMEM_RUN  = 1'b1
    } imem_state_e;

    // FSRC_ZERO exists so fetch_data reads as 0 out of reset even though the
    // RAM read register has no reset of its own.
    typedef enum logic [1:0] {
        FSRC_ZERO = 2'd0,
        FSRC_RAM  = 2'd1,
        FSRC_NOP  = 2'd2
    } fetch_src_e;

    // Byte address -> word index drops the two byte-offset bits.
    function automatic int word_idx_w(input int addr_w);
        return addr_w - 2;
    endfunction

endpackage

// File: rtl/inst_mem_loadable_if.sv
// ---------------------------------------------------------------------------
// inst_mem_loadable_if
// Bundles the boot-load stream and the fetch handshake of inst_mem_loadable.
//   master : loader / fetch stage side (drives load_* requests and fetch_req)
//   slave  : the memory itself
// Parameters must match the attached inst_mem_loadable instance.
// ---------------------------------------------------------------------------
interface inst_mem_loadable_if #(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 64
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    // Boot-load stream
    logic              load_valid;
    logic [31:0]       load_data;
    logic              load_last;
    logic              load_ready;
    logic              load_overflow;
    logic [CNT_W-1:0]  load_count;

    // Fetch handshake
    logic              fetch_req;
    logic [ADDR_W-1:0] fetch_addr;
    logic              fetch_ready;
    logic              fetch_valid;
    logic [31:0]       fetch_data;
    logic              fetch_fault;

    modport master (
        output load_valid, load_data, load_last,
        output fetch_req, fetch_addr,
        input  load_ready, load_overflow, load_count,
        input  fetch_ready, fetch_valid, fetch_data, fetch_fault
    );

    modport slave (
        input  load_valid, load_data, load_last,
        input  fetch_req, fetch_addr,
        output load_ready, load_overflow, load_count,
        output fetch_ready, fetch_valid, fetch_data, fetch_fault
    );

endinterface

// File: rtl/inst_ram_1w1r.sv
// ---------------------------------------------------------------------------
// inst_ram_1w1r
// DEPTH x 32 RAM, one write port, one synchronous read port, no reset, so it
// maps onto a block RAM.
//   clk   : rising-edge clock
//   we    : write enable; mem[waddr] <= wdata
//   re    : read enable; rdata <= mem[raddr], otherwise rdata holds
//   rdata : registered read data
// ---------------------------------------------------------------------------
module inst_ram_1w1r #(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read register holds between reads; the top relies on this to keep
    // fetch_data stable while fetch_valid is low.
    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/inst_mem_loadable.sv
// ---------------------------------------------------------------------------
// inst_mem_loadable
// Loadable instruction memory. After reset it sits in LOAD and accepts a
// program as a stream of words at an internal pointer; the word flagged
// load_last moves it to RUN, where it serves 1-cycle-latency fetches.
// Misaligned or out-of-range fetches return NOP with fetch_fault.
//   clk, rst : clock, synchronous active-high reset (RAM contents kept)
//   bus      : inst_mem_loadable_if.slave
//              load_valid/load_data/load_last in, load_ready/load_overflow/
//              load_count out; fetch_req/fetch_addr in, fetch_ready/
//              fetch_valid/fetch_data/fetch_fault out
// Constraints: DEPTH power of two (16..4096), 2**ADDR_W >= 4*DEPTH.
// ---------------------------------------------------------------------------
module inst_mem_loadable
    import riscv_mem_pkg::*;
#(
    parameter int          DEPTH    = 64,
    parameter int          ADDR_W   = 8,
    parameter logic [31:0] NOP_WORD = RV_NOP_WORD
) (
    input logic               clk,
    input logic               rst,
    inst_mem_loadable_if.slave bus
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;
    localparam int IDX_W = word_idx_w(ADDR_W);

    imem_state_e      state_q;
    imem_state_e      state_d;
    logic [CNT_W-1:0] load_count_q;
    logic             load_overflow_q;
    logic             fetch_valid_q;
    logic             fetch_fault_q;
    fetch_src_e       fetch_src_q;

    logic             in_load;
    logic             load_full;
    logic             load_accept;
    logic             load_done;
    logic [IDX_W-1:0] fetch_idx;
    logic             idx_high;
    logic             fetch_bad;
    logic             fetch_accept;
    logic             ram_we;
    logic             ram_re;
    logic [31:0]      ram_rdata;

    // Load side: pointer full means a further word is an overflow, not a write.
    // Ending the load on load_last is allowed even when that word overflowed,
    // so a too-long program still releases the core.
    always_comb begin
        in_load     = (state_q == IMEM_LOAD);
        load_full   = (load_count_q == CNT_W'(DEPTH));
        load_accept = bus.load_valid & in_load & ~load_full;
        load_done   = bus.load_valid & bus.load_last & in_load;
        ram_we      = load_accept & ~rst;
    end

    // Anything at or above DEPTH shows up as a set bit above the RAM address
    // bits because DEPTH is a power of two.
    assign fetch_idx = bus.fetch_addr[ADDR_W-1:2];

    if (IDX_W > AW) begin : g_range_check
        assign idx_high = |fetch_idx[IDX_W-1:AW];
    end else begin : g_no_range_check
        assign idx_high = 1'b0;
    end

    always_comb begin
        fetch_bad    = (bus.fetch_addr[1:0] != 2'b00) | idx_high;
        fetch_accept = bus.fetch_req & (state_q == IMEM_RUN);
        ram_re       = fetch_accept & ~fetch_bad;
    end

    // Next-state logic: RUN is left only through reset.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IMEM_LOAD: begin
                if (load_done) begin
                    state_d = IMEM_RUN;
                end
            end
            IMEM_RUN: begin
                state_d = IMEM_RUN;
            end
            default: begin
                state_d = IMEM_LOAD;
            end
        endcase
    end

    // State, load pointer and fetch response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IMEM_LOAD;
            load_count_q    <= '0;
            load_overflow_q <= 1'b0;
            fetch_valid_q   <= 1'b0;
            fetch_fault_q   <= 1'b0;
            fetch_src_q     <= FSRC_ZERO;
        end else begin
            state_q       <= state_d;
            fetch_valid_q <= fetch_accept;
            fetch_fault_q <= fetch_accept & fetch_bad;
            if (load_accept) begin
                load_count_q <= load_count_q + CNT_W'(1);
            end
            if (bus.load_valid & in_load & load_full) begin
                load_overflow_q <= 1'b1;
            end
            if (fetch_accept) begin
                fetch_src_q <= fetch_bad ? FSRC_NOP : FSRC_RAM;
            end
        end
    end

    inst_ram_1w1r #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (load_count_q[AW-1:0]),
        .wdata (bus.load_data),
        .re    (ram_re),
        .raddr (fetch_idx[AW-1:0]),
        .rdata (ram_rdata)
    );

    // fetch_data is steered rather than registered a second time, so the RAM
    // read register supplies the data with a single cycle of latency.
    always_comb begin
        bus.fetch_data = 32'h0;
        case (fetch_src_q)
            FSRC_RAM:  bus.fetch_data = ram_rdata;
            FSRC_NOP:  bus.fetch_data = NOP_WORD;
            default:   bus.fetch_data = 32'h0;
        endcase
    end

    assign bus.load_ready    = (state_q == IMEM_LOAD);
    assign bus.load_overflow = load_overflow_q;
    assign bus.load_count    = load_count_q;
    assign bus.fetch_ready   = (state_q == IMEM_RUN);
    assign bus.fetch_valid   = fetch_valid_q;
    assign bus.fetch_fault   = fetch_fault_q;

endmodule

// File: tb/tb_inst_mem_loadable.sv
// ---------------------------------------------------------------------------
// tb_inst_mem_loadable
// Directed bench for inst_mem_loadable: a DEPTH=64 instance for most
// scenarios and a DEPTH=16 instance for overflow and out-of-range fetches.
// ---------------------------------------------------------------------------
module tb_inst_mem_loadable;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    inst_mem_loadable_if #(.ADDR_W(8), .DEPTH(64)) bus ();
    inst_mem_loadable_if #(.ADDR_W(8), .DEPTH(16)) bus16 ();

    inst_mem_loadable #(.DEPTH(64), .ADDR_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    inst_mem_loadable #(.DEPTH(16), .ADDR_W(8)) dut16 (
        .clk (clk),
        .rst (rst),
        .bus (bus16)
    );

    logic [31:0] prog9 [9] = '{32'h00500093, 32'h00a00113, 32'h002081b3,
                               32'h40208233, 32'h0020f2b3, 32'h0020e333,
                               32'h0020c3b3, 32'h00309413, 32'h0000006f};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++; if (bus.load_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_load_ready got %b want 1", bus.load_ready); end
        checks++; if (bus.load_overflow !== 1'b0) begin errors++; $display("[TB] FAIL reset_overflow got %b want 0", bus.load_overflow); end
        checks++; if (bus.load_count !== 7'd0) begin errors++; $display("[TB] FAIL reset_load_count got %0d want 0", bus.load_count); end
        checks++; if (bus.fetch_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_fetch_ready got %b want 0", bus.fetch_ready); end
        checks++; if (bus.fetch_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_fetch_valid got %b want 0", bus.fetch_valid); end
        checks++; if (bus.fetch_data !== 32'h0) begin errors++; $display("[TB] FAIL reset_fetch_data got %h want 00000000", bus.fetch_data); end
        checks++; if (bus.fetch_fault !== 1'b0) begin errors++; $display("[TB] FAIL reset_fetch_fault got %b want 0", bus.fetch_fault); end
        rst = 1'b0;
    endtask

    task automatic test_stream_and_fetch();
        do_reset();
        for (int i = 0; i < 9; i++) begin
            bus.load_valid = 1'b1;
            bus.load_data  = prog9[i];
            bus.load_last  = (i == 8);
            checks++; if (bus.load_count !== 7'(i)) begin errors++; $display("[TB] FAIL stream_load_count got %0d want %0d", bus.load_count, i); end
            tick();
        end
        bus.load_valid = 1'b0;
        bus.load_last  = 1'b0;
        checks++; if (bus.load_count !== 7'd9) begin errors++; $display("[TB] FAIL stream_final_count got %0d want 9", bus.load_count); end
        checks++; if (bus.fetch_ready !== 1'b1) begin errors++; $display("[TB] FAIL stream_fetch_ready got %b want 1", bus.fetch_ready); end
        checks++; if (bus.load_ready !== 1'b0) begin errors++; $display("[TB] FAIL stream_load_ready got %b want 0", bus.load_ready); end
        checks++; if (bus.fetch_valid !== 1'b0) begin errors++; $display("[TB] FAIL stream_idle_valid got %b want 0", bus.fetch_valid); end
        for (int i = 0; i < 9; i++) begin
            bus.fetch_req  = 1'b1;
            bus.fetch_addr = 8'(i * 4);
            tick();
            checks++; if (bus.fetch_valid !== 1'b1) begin errors++; $display("[TB] FAIL b2b_valid[%0d] got %b want 1", i, bus.fetch_valid); end
            checks++; if (bus.fetch_data !== prog9[i]) begin errors++; $display("[TB] FAIL b2b_data[%0d] got %h want %h", i, bus.fetch_data, prog9[i]); end
            checks++; if (bus.fetch_fault !== 1'b0) begin errors++; $display("[TB] FAIL b2b_fault[%0d] got %b want 0", i, bus.fetch_fault); end
        end
        bus.fetch_req = 1'b0;
        tick();
        checks++; if (bus.fetch_valid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_pulse_end got %b want 0", bus.fetch_valid); end
        checks++; if (bus.fetch_data !== 32'h0000006f) begin errors++; $display("[TB] FAIL b2b_data_hold got %h want 0000006f", bus.fetch_data); end
    endtask

    task automatic test_misaligned();
        do_reset();
        bus.load_valid = 1'b1;
        bus.load_data  = 32'h00000033;
        bus.load_last  = 1'b1;
        tick();
        bus.load_valid = 1'b0;
        bus.load_last  = 1'b0;
        bus.fetch_req  = 1'b1;
        bus.fetch_addr = 8'h02;
        tick();
        checks++; if (bus.fetch_valid !== 1'b1) begin errors++; $display("[TB] FAIL misalign_valid got %b want 1", bus.fetch_valid); end
        checks++; if (bus.fetch_fault !== 1'b1) begin errors++; $display("[TB] FAIL misalign_fault got %b want 1", bus.fetch_fault); end
        checks++; if (bus.fetch_data !== 32'h00000013) begin errors++; $display("[TB] FAIL misalign_data got %h want 00000013", bus.fetch_data); end
        bus.fetch_addr = 8'h00;
        tick();
        checks++; if (bus.fetch_fault !== 1'b0) begin errors++; $display("[TB] FAIL aligned_fault got %b want 0", bus.fetch_fault); end
        checks++; if (bus.fetch_data !== 32'h00000033) begin errors++; $display("[TB] FAIL aligned_data got %h want 00000033", bus.fetch_data); end
        bus.fetch_req = 1'b0;
        tick();
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 16; i++) begin
            bus16.load_valid = 1'b1;
            bus16.load_data  = 32'hA000_0000 | 32'(i);
            bus16.load_last  = 1'b0;
            tick();
        end
        checks++; if (bus16.load_count !== 5'd16) begin errors++; $display("[TB] FAIL ovf_full_count got %0d want 16", bus16.load_count); end
        checks++; if (bus16.load_overflow !== 1'b0) begin errors++; $display("[TB] FAIL ovf_early got %b want 0", bus16.load_overflow); end
        bus16.load_data = 32'hFFFF_FFFF;
        bus16.load_last = 1'b1;
        tick();
        bus16.load_valid = 1'b0;
        bus16.load_last  = 1'b0;
        checks++; if (bus16.load_overflow !== 1'b1) begin errors++; $display("[TB] FAIL ovf_flag got %b want 1", bus16.load_overflow); end
        checks++; if (bus16.load_count !== 5'd16) begin errors++; $display("[TB] FAIL ovf_count_hold got %0d want 16", bus16.load_count); end
        checks++; if (bus16.fetch_ready !== 1'b1) begin errors++; $display("[TB] FAIL ovf_run got %b want 1", bus16.fetch_ready); end
        bus16.fetch_req  = 1'b1;
        bus16.fetch_addr = 8'h00;
        tick();
        checks++; if (bus16.fetch_data !== 32'hA000_0000) begin errors++; $display("[TB] FAIL ovf_word0 got %h want a0000000", bus16.fetch_data); end
        bus16.fetch_addr = 8'h3C;
        tick();
        checks++; if (bus16.fetch_data !== 32'hA000_000F) begin errors++; $display("[TB] FAIL ovf_word15 got %h want a000000f", bus16.fetch_data); end
        checks++; if (bus16.fetch_fault !== 1'b0) begin errors++; $display("[TB] FAIL ovf_word15_fault got %b want 0", bus16.fetch_fault); end
        bus16.fetch_addr = 8'h40;
        tick();
        checks++; if (bus16.fetch_valid !== 1'b1) begin errors++; $display("[TB] FAIL range_valid got %b want 1", bus16.fetch_valid); end
        checks++; if (bus16.fetch_fault !== 1'b1) begin errors++; $display("[TB] FAIL range_fault got %b want 1", bus16.fetch_fault); end
        checks++; if (bus16.fetch_data !== 32'h00000013) begin errors++; $display("[TB] FAIL range_data got %h want 00000013", bus16.fetch_data); end
        bus16.fetch_req = 1'b0;
        tick();
    endtask

    task automatic test_fetch_during_load();
        logic [31:0] words [3];
        words = '{32'h00100093, 32'h00200113, 32'h00300193};
        do_reset();
        bus.fetch_req  = 1'b1;
        bus.fetch_addr = 8'h00;
        for (int i = 0; i < 3; i++) begin
            bus.load_valid = 1'b1;
            bus.load_data  = words[i];
            bus.load_last  = (i == 2);
            tick();
            if (i < 2) begin
                checks++; if (bus.fetch_valid !== 1'b0) begin errors++; $display("[TB] FAIL load_fetch_valid[%0d] got %b want 0", i, bus.fetch_valid); end
            end
        end
        bus.load_valid = 1'b0;
        bus.load_last  = 1'b0;
        checks++; if (bus.fetch_valid !== 1'b0) begin errors++; $display("[TB] FAIL last_cycle_valid got %b want 0", bus.fetch_valid); end
        checks++; if (bus.fetch_ready !== 1'b1) begin errors++; $display("[TB] FAIL first_run_ready got %b want 1", bus.fetch_ready); end
        tick();
        checks++; if (bus.fetch_valid !== 1'b1) begin errors++; $display("[TB] FAIL first_run_valid got %b want 1", bus.fetch_valid); end
        checks++; if (bus.fetch_data !== 32'h00100093) begin errors++; $display("[TB] FAIL first_run_data got %h want 00100093", bus.fetch_data); end
        bus.fetch_req = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_load();
        logic [31:0] words [3];
        words = '{32'h01000513, 32'h02000593, 32'h00b50633};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            bus.load_valid = 1'b1;
            bus.load_data  = 32'h5555_0000 | 32'(i);
            bus.load_last  = 1'b0;
            tick();
        end
        checks++; if (bus.load_count !== 7'd5) begin errors++; $display("[TB] FAIL midload_count got %0d want 5", bus.load_count); end
        bus.load_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (bus.load_count !== 7'd0) begin errors++; $display("[TB] FAIL midload_rst_count got %0d want 0", bus.load_count); end
        checks++; if (bus.load_ready !== 1'b1) begin errors++; $display("[TB] FAIL midload_rst_ready got %b want 1", bus.load_ready); end
        checks++; if (bus.fetch_ready !== 1'b0) begin errors++; $display("[TB] FAIL midload_rst_fready got %b want 0", bus.fetch_ready); end
        for (int i = 0; i < 3; i++) begin
            bus.load_valid = 1'b1;
            bus.load_data  = words[i];
            bus.load_last  = (i == 2);
            tick();
        end
        bus.load_valid = 1'b0;
        bus.load_last  = 1'b0;
        bus.fetch_req  = 1'b1;
        bus.fetch_addr = 8'h08;
        tick();
        bus.fetch_req = 1'b0;
        checks++; if (bus.fetch_data !== 32'h00b50633) begin errors++; $display("[TB] FAIL reload_word2 got %h want 00b50633", bus.fetch_data); end
        checks++; if (bus.load_count !== 7'd3) begin errors++; $display("[TB] FAIL reload_count got %0d want 3", bus.load_count); end
    endtask

    task automatic test_load_in_run();
        bus.load_valid = 1'b1;
        bus.load_data  = 32'hDEADBEEF;
        bus.load_last  = 1'b0;
        tick();
        tick();
        bus.load_valid = 1'b0;
        checks++; if (bus.load_count !== 7'd3) begin errors++; $display("[TB] FAIL run_load_count got %0d want 3", bus.load_count); end
        checks++; if (bus.load_overflow !== 1'b0) begin errors++; $display("[TB] FAIL run_load_overflow got %b want 0", bus.load_overflow); end
        bus.fetch_req  = 1'b1;
        bus.fetch_addr = 8'h00;
        tick();
        bus.fetch_req = 1'b0;
        checks++; if (bus.fetch_data !== 32'h01000513) begin errors++; $display("[TB] FAIL run_word0 got %h want 01000513", bus.fetch_data); end
        bus.fetch_req  = 1'b1;
        bus.fetch_addr = 8'h0C;
        tick();
        bus.fetch_req = 1'b0;
        checks++; if (bus.fetch_data === 32'hDEADBEEF) begin errors++; $display("[TB] FAIL run_word3 got %h want not deadbeef", bus.fetch_data); end
    endtask

    task automatic test_reset_mid_fetch();
        bus.fetch_req  = 1'b1;
        bus.fetch_addr = 8'h04;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.fetch_req = 1'b0;
        checks++; if (bus.fetch_valid !== 1'b0) begin errors++; $display("[TB] FAIL rstfetch_valid got %b want 0", bus.fetch_valid); end
        checks++; if (bus.fetch_data !== 32'h0) begin errors++; $display("[TB] FAIL rstfetch_data got %h want 00000000", bus.fetch_data); end
        checks++; if (bus.fetch_ready !== 1'b0) begin errors++; $display("[TB] FAIL rstfetch_ready got %b want 0", bus.fetch_ready); end
        tick();
        checks++; if (bus.fetch_valid !== 1'b0) begin errors++; $display("[TB] FAIL rstfetch_after got %b want 0", bus.fetch_valid); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.load_valid   = 1'b0;
        bus.load_data    = 32'h0;
        bus.load_last    = 1'b0;
        bus.fetch_req    = 1'b0;
        bus.fetch_addr   = 8'h0;
        bus16.load_valid = 1'b0;
        bus16.load_data  = 32'h0;
        bus16.load_last  = 1'b0;
        bus16.fetch_req  = 1'b0;
        bus16.fetch_addr = 8'h0;

        test_reset();
        test_stream_and_fetch();
        test_misaligned();
        test_overflow();
        test_fetch_during_load();
        test_reset_mid_load();
        test_load_in_run();
        test_reset_mid_fetch();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/inst_mem_loadable.md
Name: inst_mem_loadable

Overview:
Parametrised, loadable instruction memory for the single-cycle/pipelined RISC-V core.
- Replaces hard-coded initial-block contents with a boot-load port: words stream in sequentially from a loader (UART/testbench) while the core is held off.
- After loading, serves fetches from a synchronous-read RAM with a req/valid handshake.
- Flags misaligned or out-of-range fetches.
- Sits between the PC/fetch stage and the loader.

Parameters:
- DEPTH, 64, number of 32-bit words; power of two, 16..4096.
- ADDR_W, 8, byte-address width of fetch_addr; must satisfy 2^ADDR_W >= 4*DEPTH.
- NOP_WORD, 32'h00000013, word returned on a faulted fetch (addi x0,x0,0).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- load_valid  in  1  load_data word is presented this cycle.
- load_data  in  32  instruction word; written at the internal load pointer.
- load_last  in  1  qualifies load_valid; this word ends the program.
- load_ready  out  1  memory accepts load words (state LOAD).
- load_overflow  out  1  sticky: a word arrived with the pointer at DEPTH.
- load_count  out  $clog2(DEPTH)+1  words written since reset.
- fetch_req  in  1  fetch request (accepted only in RUN).
- fetch_addr  in  ADDR_W  byte address from the PC.
- fetch_ready  out  1  high in RUN only.
- fetch_valid  out  1  fetch_data is valid; one cycle after an accepted request.
- fetch_data  out  32  instruction, or NOP_WORD on fault.
- fetch_fault  out  1  with fetch_valid: addr[1:0]!=0 or word index >= DEPTH.

Behaviour:
- State machine, 2 states:
  - LOAD (reset state) -> RUN on an accepted word with load_last=1, or on load_valid&load_last while overflowed.
  - RUN -> LOAD only via rst.
- Reset values: state=LOAD, load_ready=1, load_overflow=0, load_count=0, fetch_ready=0, fetch_valid=0, fetch_data=0, fetch_fault=0.
- RAM contents are NOT cleared by rst.
- Load accept = load_valid & load_ready & (load_count < DEPTH).
  - On accept: mem[load_count] <= load_data; load_count++.
  - load_valid with load_count==DEPTH: write dropped, load_overflow<=1 (sticky until rst), load_count holds.
- Last word: load_last on the accepted word -> write it, go to RUN next cycle. load_ready falls and fetch_ready rises on the same edge.
- In RUN, load_valid is ignored (no write, no overflow).
- Fetch accept = fetch_req & fetch_ready.
  - Word index = fetch_addr[ADDR_W-1:2].
  - Fault if fetch_addr[1:0]!=0 or index >= DEPTH.
  - Next cycle: fetch_valid=1.
  - No fault: fetch_data=mem[index], fetch_fault=0.
  - Fault: fetch_data=NOP_WORD, fetch_fault=1, and no RAM read is required.
- fetch_valid is a one-cycle pulse per accepted request.
- Back-to-back requests are fully pipelined: throughput 1/cycle, latency 1.
- fetch_data holds its last value while fetch_valid=0.
- In LOAD, fetch_req is ignored and fetch_valid stays 0.
- Reset mid-load: state=LOAD, pointer=0. Previously written words remain but will be overwritten by the new load.
- Reset mid-fetch: a fetch accepted in the cycle rst is high produces no fetch_valid; fetch_valid=0 the cycle after rst.
- Unwritten locations read as X in simulation. Verification must only fetch loaded words or check the fault path.

Decomposition:
Shared package riscv_mem_pkg:
- NOP_WORD constant (also used by the pipeline flush logic).
- State encoding (IMEM_LOAD, IMEM_RUN).
- Word-index extraction helper width rule.

One sub-module, inst_ram_1w1r:
- DEPTH x 32, one write port, one synchronous read port, no reset.
- Inferable as BRAM.

Control FSM, counter and fault logic stay in inst_mem_loadable.

Test Plan:
1. Reset, stream 9 words (last with load_last) at 1/cycle:
   - load_count 0..9;
   - fetch_ready=1 the cycle after the 9th word;
   - fetch 0x00,0x04,...,0x20 back-to-back -> 9 consecutive fetch_valid pulses with matching words, 1-cycle latency.
2. Load 0x00000033 at word 0, then fetch_addr=0x02 -> fetch_valid=1, fetch_fault=1, fetch_data=0x00000013.
3. DEPTH=16: load 16 words without load_last, then a 17th with load_last:
   - load_overflow=1, load_count=16, word 0 unchanged, state RUN;
   - fetch 0x40 -> fault with NOP.
4. fetch_req held high during LOAD -> no fetch_valid; after load_last, the first valid returns the next cycle only for a request made in RUN.
5. After 5 words loaded, assert rst one cycle:
   - load_count=0, load_ready=1, fetch_ready=0;
   - reload 3 words with last -> fetch 0x08 returns the new 3rd word.
6. In RUN, drive load_valid with 0xDEADBEEF -> load_count unchanged, fetch 0x00 still returns the originally loaded word 0.
